// File: rtl/layer_argmax_8_16.sv
// Streaming argmax over M signed T-bit elements per frame with a one-beat result handshake.
// Define ARGMAX_TIE_LAST_EN to let the highest index win on equal maxima (default: lowest index wins).
module layer_argmax_8_16 #(
    parameter int M    = 8,
    parameter int T    = 16,
    parameter int LOGM = 3
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 s_valid,
    output logic                 s_ready,
    input  logic signed [T-1:0]  data_in,
    output logic                 m_valid,
    input  logic                 m_ready,
    output logic [LOGM-1:0]      idx_out,
    output logic signed [T-1:0]  max_out
);

    typedef enum logic [0:0] {
        S_ACC = 1'b0,
        S_OUT = 1'b1
    } state_t;

    localparam logic [LOGM-1:0] CNT_LAST = LOGM'(M - 1);

    state_t                state_q, state_d;
    logic [LOGM-1:0]       cnt_q, cnt_d;
    logic signed [T-1:0]   max_q, max_d;
    logic [LOGM-1:0]       idx_q, idx_d;
    logic                  s_ready_s;
    logic                  m_valid_s;

    function automatic logic take_new(input logic signed [T-1:0] cand,
                                      input logic signed [T-1:0] cur);
`ifdef ARGMAX_TIE_LAST_EN
        return (cand >= cur);
`else
        return (cand > cur);
`endif
    endfunction

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_ACC;
        end else begin
            state_q <= state_d;
        end
    end

    // Running max, index and element counter registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q <= {LOGM{1'b0}};
            max_q <= {T{1'b0}};
            idx_q <= {LOGM{1'b0}};
        end else begin
            cnt_q <= cnt_d;
            max_q <= max_d;
            idx_q <= idx_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_ACC: begin
                if (s_valid && (cnt_q == CNT_LAST)) begin
                    state_d = S_OUT;
                end else begin
                    state_d = S_ACC;
                end
            end
            S_OUT: begin
                if (m_ready) begin
                    state_d = S_ACC;
                end else begin
                    state_d = S_OUT;
                end
            end
            default: state_d = S_ACC;
        endcase
    end

    // Datapath update; element 0 always seeds the max so the reset value never competes.
    always_comb begin
        cnt_d = cnt_q;
        max_d = max_q;
        idx_d = idx_q;
        if ((state_q == S_ACC) && s_valid) begin
            if (cnt_q == {LOGM{1'b0}}) begin
                max_d = data_in;
                idx_d = {LOGM{1'b0}};
            end else if (take_new(data_in, max_q)) begin
                max_d = data_in;
                idx_d = cnt_q;
            end else begin
                max_d = max_q;
                idx_d = idx_q;
            end
            if (cnt_q == CNT_LAST) begin
                cnt_d = {LOGM{1'b0}};
            end else begin
                cnt_d = cnt_q + LOGM'(1);
            end
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Handshake outputs decoded from state only.
    always_comb begin
        s_ready_s = 1'b1;
        m_valid_s = 1'b0;
        case (state_q)
            S_ACC: begin
                s_ready_s = 1'b1;
                m_valid_s = 1'b0;
            end
            S_OUT: begin
                s_ready_s = 1'b0;
                m_valid_s = 1'b1;
            end
            default: begin
                s_ready_s = 1'b1;
                m_valid_s = 1'b0;
            end
        endcase
    end

    assign s_ready = s_ready_s;
    assign m_valid = m_valid_s;
    assign idx_out = idx_q;
    assign max_out = max_q;

endmodule

// File: tb/tb_layer_argmax_8_16.sv
// Directed bench for layer_argmax_8_16; expectations follow ARGMAX_TIE_LAST_EN when defined.
module tb_layer_argmax_8_16;

    logic               clk;
    logic               reset;
    logic               s_valid;
    logic               s_ready;
    logic signed [15:0] data_in;
    logic               m_valid;
    logic               m_ready;
    logic [2:0]         idx_out;
    logic signed [15:0] max_out;

    int n_vec;
    int n_err;

    logic [15:0] fr [8];

    layer_argmax_8_16 dut (
        .clk     (clk),
        .reset   (reset),
        .s_valid (s_valid),
        .s_ready (s_ready),
        .data_in (data_in),
        .m_valid (m_valid),
        .m_ready (m_ready),
        .idx_out (idx_out),
        .max_out (max_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference argmax: scan all elements, tie rule selected by the macro.
    task automatic ref_argmax(input logic [15:0] v [8], output int idx, output logic [15:0] mx);
        idx = 0;
        mx  = v[0];
        for (int i = 1; i < 8; i++) begin
`ifdef ARGMAX_TIE_LAST_EN
            if ($signed(v[i]) >= $signed(mx)) begin idx = i; mx = v[i]; end
`else
            if ($signed(v[i]) > $signed(mx)) begin idx = i; mx = v[i]; end
`endif
        end
    endtask

    // Send one frame, with up to max_gap idle (garbage-data) cycles before each element.
    // Returns right after the edge that transfers the last element.
    task automatic send_frame(input logic [15:0] v [8], input int max_gap);
        int gap;
        int b;
        for (int i = 0; i < 8; i++) begin
            gap = (max_gap > 0) ? $urandom_range(0, max_gap) : 0;
            for (int g = 0; g < gap; g++) begin
                s_valid = 1'b0;
                data_in = 16'($urandom);
                step();
            end
            s_valid = 1'b1;
            data_in = v[i];
            b = 0;
            while (!s_ready && b < 20) begin
                step();
                b++;
            end
            if (b == 20) check("s_ready_timeout", 32'd0, 32'd1);
            if (i == 7) check("mvalid_before_last", {31'd0, m_valid}, 32'd0);
            step();
        end
        s_valid = 1'b0;
        data_in = 16'd0;
    endtask

    initial begin
        int          e_idx;
        logic [15:0] e_max;
        int          b;
        bit          got;

        n_vec   = 0;
        n_err   = 0;
        reset   = 1'b0;
        s_valid = 1'b0;
        data_in = 16'd0;
        m_ready = 1'b1;

        // Reset state
        #3;
        check("rst_s_ready", {31'd0, s_ready}, 32'd1);
        check("rst_m_valid", {31'd0, m_valid}, 32'd0);
        check("rst_idx",     {29'd0, idx_out}, 32'd0);
        check("rst_max",     {16'd0, max_out}, 32'd0);
        step();
        reset = 1'b1;
        step();

        // Frame A, continuous valid, m_ready high
        fr = '{16'd5, -16'sd3, 16'd20, 16'd7, 16'd20, -16'sd1, 16'd0, 16'd4};
        send_frame(fr, 0);
        check("A_m_valid", {31'd0, m_valid}, 32'd1);
        check("A_s_ready", {31'd0, s_ready}, 32'd0);
`ifdef ARGMAX_TIE_LAST_EN
        check("A_idx", {29'd0, idx_out}, 32'd4);
`else
        check("A_idx", {29'd0, idx_out}, 32'd2);
`endif
        check("A_max", {16'd0, max_out}, 32'd20);
        step();
        check("A_done_m_valid", {31'd0, m_valid}, 32'd0);
        check("A_done_s_ready", {31'd0, s_ready}, 32'd1);

        // All-negative frame
        fr = '{-16'sd5, -16'sd2, -16'sd9, -16'sd2, -16'sd100, -16'sd7, -16'sd3, 16'h8000};
        send_frame(fr, 0);
        check("N_m_valid", {31'd0, m_valid}, 32'd1);
`ifdef ARGMAX_TIE_LAST_EN
        check("N_idx", {29'd0, idx_out}, 32'd3);
`else
        check("N_idx", {29'd0, idx_out}, 32'd1);
`endif
        check("N_max", {16'd0, max_out}, 32'h0000FFFE);
        step();

        // All most-negative frame
        for (int i = 0; i < 8; i++) fr[i] = 16'h8000;
        send_frame(fr, 0);
`ifdef ARGMAX_TIE_LAST_EN
        check("MIN_idx", {29'd0, idx_out}, 32'd7);
`else
        check("MIN_idx", {29'd0, idx_out}, 32'd0);
`endif
        check("MIN_max", {16'd0, max_out}, 32'h00008000);
        step();

        // Backpressure: result held 5 cycles while upstream keeps offering data
        m_ready = 1'b0;
        fr = '{16'd5, -16'sd3, 16'd20, 16'd7, 16'd20, -16'sd1, 16'd0, 16'd4};
        send_frame(fr, 0);
        s_valid = 1'b1;
        data_in = 16'd999;
        for (int c = 0; c < 5; c++) begin
            check("BP_m_valid", {31'd0, m_valid}, 32'd1);
            check("BP_s_ready", {31'd0, s_ready}, 32'd0);
`ifdef ARGMAX_TIE_LAST_EN
            check("BP_idx", {29'd0, idx_out}, 32'd4);
`else
            check("BP_idx", {29'd0, idx_out}, 32'd2);
`endif
            check("BP_max", {16'd0, max_out}, 32'd20);
            step();
        end
        s_valid = 1'b0;
        m_ready = 1'b1;
        step();
        check("BP_done_m_valid", {31'd0, m_valid}, 32'd0);
        check("BP_done_s_ready", {31'd0, s_ready}, 32'd1);

        // Async reset while a result is pending
        m_ready = 1'b0;
        send_frame(fr, 0);
        check("AR_pre_m_valid", {31'd0, m_valid}, 32'd1);
        #2 reset = 1'b0;
        #1;
        check("AR_m_valid", {31'd0, m_valid}, 32'd0);
        check("AR_s_ready", {31'd0, s_ready}, 32'd1);
        check("AR_idx",     {29'd0, idx_out}, 32'd0);
        check("AR_max",     {16'd0, max_out}, 32'd0);
        #1 reset = 1'b1;
        m_ready = 1'b1;
        step();

        // Mid-frame reset discards partial frame
        s_valid = 1'b1;
        data_in = 16'd100; step();
        data_in = 16'd1;   step();
        data_in = 16'd1;   step();
        s_valid = 1'b0;
        #1 reset = 1'b0;
        #1;
        check("MR_max_cleared", {16'd0, max_out}, 32'd0);
        #1 reset = 1'b1;
        step();
        fr = '{16'd1, 16'd2, 16'd3, 16'd4, 16'd5, 16'd6, 16'd7, 16'd8};
        send_frame(fr, 0);
        check("MR_m_valid", {31'd0, m_valid}, 32'd1);
        check("MR_idx", {29'd0, idx_out}, 32'd7);
        check("MR_max", {16'd0, max_out}, 32'd8);
        step();

        // Random frames with gaps and random downstream readiness
        for (int f = 0; f < 50; f++) begin
            for (int i = 0; i < 8; i++) fr[i] = 16'($urandom_range(0, 15)) - 16'd8;
            if (f % 5 == 0) for (int i = 0; i < 8; i++) fr[i] = 16'($urandom);
            ref_argmax(fr, e_idx, e_max);
            m_ready = 1'b0;
            send_frame(fr, 4);
            s_valid = 1'b1;
            got = 1'b0;
            b = 0;
            while (!got && b < 50) begin
                data_in = 16'($urandom);
                m_ready = 1'($urandom_range(0, 1));
                if (m_valid) check("R_no_accept", {31'd0, s_ready}, 32'd0);
                if (m_valid && m_ready) begin
                    check("R_idx", {29'd0, idx_out}, 32'(e_idx));
                    check("R_max", {16'd0, max_out}, {16'd0, e_max});
                    got = 1'b1;
                end
                step();
                b++;
            end
            if (!got) check("R_result_timeout", 32'd0, 32'd1);
            s_valid = 1'b0;
            m_ready = 1'b0;
            check("R_after_m_valid", {31'd0, m_valid}, 32'd0);
            check("R_after_s_ready", {31'd0, s_ready}, 32'd1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/layer_argmax_8_16.md
# layer_argmax_8_16

Streaming argmax classifier that sits directly downstream of the layer_8_4_1_16 output stage. It consumes one frame of M signed T-bit layer outputs through a valid/ready handshake and tracks the running maximum and its index. It then presents the winning index and value on a single output beat with valid/ready handshake. It carries no memory beyond the running max and index, and accepts frames back-to-back apart from one bubble per frame.

## Interface
- M, 8: elements per frame (layer output length).
- T, 16: data width, signed two's complement.
- LOGM, 3: index width, = ceil(log2(M)).
- clk  input  1  rising-edge clock, single clock domain.
- reset  input  1  asynchronous, active-low reset. Asserting low clears all state immediately, independent of clk.
- s_valid  input  1  upstream data valid (driven by the layer's m_valid).
- s_ready  output  1  block can accept data_in this cycle (drives the layer's m_ready).
- data_in  input  T  signed layer output element.
- m_valid  output  1  result beat valid.
- m_ready  input  1  downstream accepts result.
- idx_out  output  LOGM  index (0..M-1) of the maximum element in the frame.
- max_out  output  T  signed maximum value of the frame.

## Operation
- Element transfer: s_valid && s_ready at a rising edge.
- Result transfer: m_valid && m_ready at a rising edge.
- State machine has two states:
  - S_ACC: s_ready=1, m_valid=0.
  - S_OUT: s_ready=0, m_valid=1.
- Reset values: state=S_ACC, cnt=0, max_r=0, idx_r=0. Outputs under reset: s_ready=1, m_valid=0, idx_out=0, max_out=0.
- Behaviour in S_ACC, on each element transfer:
  - cnt==0: max_r<=data_in, idx_r<=0 unconditionally.
  - cnt>0 and compare true: max_r<=data_in, idx_r<=cnt.
  - cnt increments on every transfer.
  - Transfer with cnt==M-1: cnt<=0, state<=S_OUT. Compare and update apply to this last element too.
- Compare is a signed comparison of data_in against max_r, full T bits. No saturation or rescaling; max_out is bit-exact to the winning input.
- Cycles without an element transfer in S_ACC (s_valid low) hold all state. Gaps of any length mid-frame are legal.
- S_OUT: idx_out=idx_r and max_out=max_r, held stable while m_valid=1 and m_ready=0. On result transfer, state<=S_ACC.
- In S_ACC, idx_out and max_out show the running values. They are meaningful only while m_valid=1.
- s_ready is a combinational function of state only. It never depends on s_valid or m_ready, so there is no combinational path through the block.
- Reset asserted mid-frame discards the partial frame. The next element after release is element 0 of a new frame.
- Reset asserted in S_OUT drops the pending result. m_valid falls immediately, asynchronously.

## Timing
- Latency: last element transferred at edge k → m_valid=1 after edge k; result is first acceptable at edge k+1.
- After result transfer at edge j, s_ready=1 after edge j. The first element of the next frame is acceptable at edge j+1.
- Minimum frame period is M+1 cycles: M element cycles plus one output cycle.
- Element and result transfers can never occur in the same cycle, because s_ready and m_valid are mutually exclusive.
- All outputs are registered or decoded from registered state. idx_out and max_out change only at clk edges or on async reset.

## Configuration
- ARGMAX_TIE_LAST_EN undefined (default):
  - Compare is strict: data_in > max_r.
  - On equal maxima, the lowest index wins.
- ARGMAX_TIE_LAST_EN defined:
  - Compare is data_in >= max_r.
  - On equal maxima, the highest index wins.
- The macro affects nothing else.

## Test plan
- Frame [5,-3,20,7,20,-1,0,4] with s_valid held high and m_ready high:
  - Default: idx_out=2, max_out=20.
  - With ARGMAX_TIE_LAST_EN: idx_out=4.
  - In both cases m_valid rises exactly 1 cycle after the 8th transfer.
- All-negative frame [-5,-2,-9,-2,-100,-7,-3,-32768] → idx_out=1, max_out=-2 (default). This checks the signed compare and that max_r is not initialised from reset value 0.
- Frame of eight -32768 values → default idx_out=0, max_out=-32768; with ARGMAX_TIE_LAST_EN, idx_out=7.
- Backpressure: complete the first frame above with m_ready=0 for 5 cycles.
  - Expect m_valid=1, idx_out/max_out stable, and s_ready=0 throughout.
  - Then raise m_ready: exactly one result transfer, s_ready=1 on the next cycle.
- Mid-frame reset: send 3 elements [100,1,1], pulse reset low asynchronously between edges, then send [1,2,3,4,5,6,7,8] → result idx_out=7, max_out=8. m_valid must drop with reset without waiting for clk.
- Random s_valid gaps (0–4 idle cycles) and random m_ready over 50 back-to-back frames, checked against a reference model. Also check that no element is accepted while m_valid=1.
